// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg -- shared widths, command record and FSM state type for the
// ALU command driver slice (alu_cmd_driver and its cmd_fifo queue).
//   DATA_W  : operand / result width
//   OP_W    : opcode width
//   COUNT_W : completed-response counter width
//   CMD_W   : width of one queued command (two operands plus opcode)
package alu_drv_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned CMD_W   = 2 * DATA_W + OP_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } drv_state_e;

    // One queued command; packed so it travels through the FIFO as a vector.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo -- synchronous command queue with first-word-fall-through read.
//   clk, rst : clock, asynchronous active-high reset (pointers/occupancy only)
//   push     : write request; ignored while full
//   wr_data  : data written at the tail
//   pop      : read request; ignored while empty
//   rd_data  : head entry, valid whenever empty is low
//   full     : DEPTH entries held
//   empty    : no entries held
// DEPTH must be a power of two (pointers wrap naturally).
module cmd_fifo
    import alu_drv_pkg::*;
#(
    parameter int unsigned WIDTH = CMD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // A push while full is refused even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver -- queues operand/opcode commands, presents each one to an
// external combinational ALU, waits SETTLE_CYCLES, captures the result and
// offers it downstream with a valid/ready handshake.
//   clk, rst               : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    : upstream command handshake
//   cmd_a, cmd_b, cmd_op   : command operands and opcode (opcode uninterpreted)
//   alu_a, alu_b, alu_opcode : operands driven to the ALU
//   alu_x                  : ALU result
//   rsp_valid/rsp_ready    : downstream response handshake
//   rsp_x, rsp_op          : captured result and echo of the issued opcode
//   op_count               : completed responses, wraps at 2**COUNT_W
//   busy                   : a command is in flight or queued
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    input  logic [OP_W-1:0]    cmd_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_opcode,
    input  logic [DATA_W-1:0]  alu_x,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_x,
    output logic [OP_W-1:0]    rsp_op,
    output logic [COUNT_W-1:0] op_count,
    output logic               busy
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    drv_state_e       state;
    drv_state_e       state_nxt;
    cmd_t             fifo_in;
    cmd_t             fifo_out;
    cmd_t             ops;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             load_ops;
    logic             capture;
    logic             rsp_fire;
    logic [SET_W-1:0] settle_cnt;

    assign fifo_in = '{op: cmd_op, a: cmd_a, b: cmd_b};

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data (fifo_in),
        .pop     (fifo_pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        load_ops  = 1'b0;
        capture   = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_ops  = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_fire = 1'b1;
                    // Chain straight into the next command to avoid an idle bubble.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        load_ops  = 1'b1;
                        state_nxt = ST_DRIVE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops        <= '0;
            settle_cnt <= '0;
            rsp_x      <= '0;
            rsp_op     <= '0;
            op_count   <= '0;
        end else begin
            if (load_ops) begin
                ops        <= fifo_out;
                settle_cnt <= '0;
            end else if (state == ST_DRIVE && !capture) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (capture) begin
                rsp_x  <= alu_x;
                rsp_op <= ops.op;
            end
            if (rsp_fire) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    assign alu_a      = ops.a;
    assign alu_b      = ops.b;
    assign alu_opcode = ops.op;
    assign rsp_valid  = (state == ST_RESP);
    assign cmd_ready  = !fifo_full;
    assign busy       = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-002 Parameter SETTLE_CYCLES, default 1, cycles operands are held on the ALU before alu_x is sampled (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  command queue can accept.
REQ-007 cmd_a, cmd_b  input  4 each  operands.
REQ-008 cmd_op  input  3  opcode, passed through uninterpreted.
REQ-009 alu_a, alu_b  output  4 each  operands driven to the combinational ALU.
REQ-010 alu_opcode  output  3  opcode driven to the ALU.
REQ-011 alu_x  input  4  ALU result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  downstream accepts result.
REQ-014 rsp_x  output  4  captured result; rsp_op output 3, echo of issued opcode.
REQ-015 op_count  output  8  completed-response counter.
REQ-016 busy  output  1  high when FSM not IDLE or queue non-empty.

Function
REQ-017 Command accepted on rising edge with cmd_valid && cmd_ready; written to FIFO tail.
REQ-018 cmd_ready SHALL equal !fifo_full; no bypass when full, even if a pop occurs that cycle.
REQ-019 Simultaneous push and pop on a non-full FIFO SHALL both occur; occupancy unchanged.
REQ-020 FSM states IDLE, DRIVE, RESP.
REQ-021 IDLE: if FIFO non-empty, pop head into operand/opcode registers, clear settle counter, go DRIVE; else stay.
REQ-022 alu_a/alu_b/alu_opcode SHALL be driven from operand registers, stable throughout DRIVE and RESP.
REQ-023 DRIVE: after SETTLE_CYCLES cycles in DRIVE, capture alu_x into rsp_x, go RESP.
REQ-024 RESP: rsp_valid=1; rsp_x, rsp_op stable until rsp_valid && rsp_ready.
REQ-025 On RESP handshake: op_count increments (255 wraps to 0); if FIFO non-empty, pop and go DRIVE same edge, else IDLE.
REQ-026 Latency (SETTLE_CYCLES=1, idle, empty FIFO): accept at edge N, rsp_valid high after edge N+2.
REQ-027 Throughput with rsp_ready held 1: one response per SETTLE_CYCLES+1 cycles.
REQ-028 Responses SHALL be in command acceptance order; none dropped or duplicated.
REQ-029 Maximum commands outstanding: FIFO_DEPTH queued plus one in operand registers.

Reset
REQ-030 rst asserted: FSM to IDLE, FIFO pointers/occupancy 0, operand registers 0, rsp_x 0, rsp_op 0, rsp_valid 0, op_count 0, busy 0; cmd_ready 1 after release.
REQ-031 Reset mid-operation SHALL discard in-flight and queued commands with no response emitted.

Structure
REQ-032 Package alu_drv_pkg SHALL hold DATA_W=4, OP_W=3, COUNT_W=8 and the FSM state type.
REQ-033 Command queue SHALL be a sub-module cmd_fifo (DATA_W*2+OP_W wide, FIFO_DEPTH deep, full/empty flags).

Verification (bench ALU stub: alu_x = (alu_a+alu_b) mod 16)
REQ-034 Single: a=5,b=3,op=100, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_x=8, rsp_op=100, op_count=1.
REQ-035 Fill: rsp_ready=0, 6 back-to-back commands -> 5 accepted, cmd_ready low on 6th; rsp_ready=1 -> 5 in-order responses, then 6th accepted.
REQ-036 Backpressure: a=10,b=6 with rsp_ready=0 for 10 cycles -> rsp_valid high, rsp_x=0 and alu_a=10 stable all 10 cycles; single handshake when released.
REQ-037 Streaming: 8 commands, rsp_ready=1 -> responses every 2 cycles, all correct mod 16 (e.g. 14+8 -> 6).
REQ-038 Reset in DRIVE with 3 queued -> all outputs reset values next cycle, no rsp_valid afterwards, busy=0.
REQ-039 Wrap: 256 completed responses -> op_count=0; 257th -> 1.
